// File: rtl/conv_out_serializer.sv
// conv_out_serializer
//   Drain side of the conv layer output bus. A full vector of N_CH parallel
//   channel words is captured into one bank of a two-bank ping-pong buffer.
//   The buffered vectors are then streamed out one channel per cycle on a
//   valid/ready interface. The producer cannot be stalled, so a vector offered
//   while both banks are full is dropped. The drop sets a sticky flag and
//   increments a saturating counter.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   in_data holds a complete vector this cycle
//   in_data    channel c at bits [c*DW +: DW]
//   in_ready   a bank is free (buffered vector count < 2)
//   out_valid  out_data / out_ch / out_last are valid
//   out_ready  downstream accepts the current word
//   out_data   current channel word, passed through bit-exact
//   out_ch     channel index of out_data
//   out_last   out_ch == N_CH-1 while out_valid
//   overflow   sticky: at least one vector was dropped
//   drop_cnt   number of dropped vectors, saturating at 16'hFFFF

module conv_out_serializer #(
    parameter int unsigned N_CH = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned CW   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [N_CH*DW-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [CW-1:0]      out_ch,
    output logic               out_last,
    output logic               overflow,
    output logic [15:0]        drop_cnt
);

    localparam logic [CW-1:0] LastCh = CW'(N_CH - 1);

    logic [DW-1:0] bank_q [2][N_CH];

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    count_q, count_d;
    logic [CW-1:0] ch_idx_q, ch_idx_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic capture;
    logic drop;
    logic pop;
    logic last_pop;

    // All handshake outputs are decoded from registered state only.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_ch    = ch_idx_q;
    assign out_last  = out_valid && (ch_idx_q == LastCh);
    assign out_data  = bank_q[rd_bank_q][ch_idx_q];
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    assign capture  = in_valid && in_ready;
    assign drop     = in_valid && !in_ready;
    assign pop      = out_valid && out_ready;
    assign last_pop = pop && out_last;

    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        count_d    = count_q;
        ch_idx_d   = ch_idx_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (capture) begin
            wr_bank_d = ~wr_bank_q;
        end

        if (pop) begin
            if (ch_idx_q == LastCh) begin
                ch_idx_d  = '0;
                rd_bank_d = ~rd_bank_q;
            end else begin
                ch_idx_d = ch_idx_q + CW'(1);
            end
        end

        // A capture that coincides with the last pop leaves the count unchanged.
        unique case ({capture, last_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            count_q    <= 2'd0;
            ch_idx_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            count_q    <= count_d;
            ch_idx_q   <= ch_idx_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Bank storage is not reset; contents are only read after a capture.
    always_ff @(posedge clk) begin
        if (capture && !rst) begin
            for (int c = 0; c < N_CH; c++) begin
                bank_q[wr_bank_q][c] <= in_data[c*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_conv_out_serializer.sv
module tb_conv_out_serializer;

    localparam int N_CH = 32;
    localparam int DW   = 32;
    localparam int CW   = 5;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic [N_CH*DW-1:0] in_data;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic [CW-1:0]      out_ch;
    logic               out_last;
    logic               overflow;
    logic [15:0]        drop_cnt;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    logic [CW+DW-1:0] sb [$];

    conv_out_serializer #(
        .N_CH(N_CH),
        .DW  (DW),
        .CW  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_last (out_last),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: samples on the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        logic [CW+DW-1:0] exp_w;
        logic [DW-1:0]    w;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                hs_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got ch=%0d data=%h, required no output",
                             out_ch, out_data);
                end else begin
                    exp_w = sb.pop_front();
                    if ({out_ch, out_data} !== exp_w) begin
                        errors++;
                        $display("FAIL sb_word: got ch=%0d data=%h, required ch=%0d data=%h",
                                 out_ch, out_data, exp_w[CW+DW-1:DW], exp_w[DW-1:0]);
                    end
                end
                checks++;
                if (out_last !== (out_ch == CW'(N_CH - 1))) begin
                    errors++;
                    $display("FAIL sb_last: got out_last=%b at ch=%0d", out_last, out_ch);
                end
            end
            if (in_valid && in_ready) begin
                for (int c = 0; c < N_CH; c++) begin
                    w = in_data[c*DW +: DW];
                    sb.push_back({CW'(c), w});
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_CH*DW-1:0] mk_vec(input logic [6:0] hi);
        logic [N_CH*DW-1:0] v;
        for (int c = 0; c < N_CH; c++) begin
            v[c*DW +: DW] = {hi, 25'(c)};
        end
        return v;
    endfunction

    function automatic logic [N_CH*DW-1:0] rnd_vec();
        logic [N_CH*DW-1:0] v;
        for (int c = 0; c < N_CH; c++) begin
            v[c*DW +: DW] = $urandom;
        end
        return v;
    endfunction

    // Offer one vector for a single cycle.
    task automatic send(input logic [N_CH*DW-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        out_ready = 1'b1;
        while ((out_valid || sb.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: out_valid=%b pending=%0d after %0d cycles, required 0/0",
                     name, out_valid, sb.size(), n);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cycle();
        cycle();
        checks++;
        if ({out_valid, out_last, out_ch, in_ready, overflow, drop_cnt} !==
            {1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset: vld=%b last=%b ch=%0d rdy=%b ovf=%b drops=%0d, required 0 0 0 1 0 0",
                     out_valid, out_last, out_ch, in_ready, overflow, drop_cnt);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pre: out_valid=%b, required 0", out_valid);
        end
        send(mk_vec(7'b0100001));
        for (int i = 0; i < N_CH; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_ch !== CW'(i) || out_last !== (i == N_CH - 1)) begin
                errors++;
                $display("FAIL single_seq: vld=%b ch=%0d last=%b, required 1 %0d %b",
                         out_valid, out_ch, out_last, i, (i == N_CH - 1));
            end
            cycle();
        end
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL single_end: out_valid=%b pending=%0d, required 0 0",
                     out_valid, sb.size());
        end
    endtask

    task automatic test_stall();
        int            hs0;
        int            n;
        logic [DW-1:0] pd;
        logic [CW-1:0] pc;
        logic          pr;
        hs0 = hs_cnt;
        out_ready = 1'b1;
        send(mk_vec(7'h11));
        n = 0;
        while (out_valid && n < 200) begin
            pd = out_data;
            pc = out_ch;
            pr = out_ready;
            cycle();
            n++;
            if (!pr && out_valid) begin
                checks++;
                if (out_data !== pd || out_ch !== pc) begin
                    errors++;
                    $display("FAIL stall_hold: ch=%0d data=%h, required ch=%0d data=%h",
                             out_ch, out_data, pc, pd);
                end
            end
            out_ready = ~out_ready;
        end
        drain("stall", 10);
        checks++;
        if (hs_cnt - hs0 != N_CH) begin
            errors++;
            $display("FAIL stall_hs: got %0d handshakes, required %0d", hs_cnt - hs0, N_CH);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk_vec(7'h21);
        cycle();
        in_data   = mk_vec(7'h22);
        cycle();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ovf_ready: in_ready=%b, required 0", in_ready);
        end
        in_data = mk_vec(7'h23);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ovf_flag: overflow=%b drop_cnt=%0d, required 1 1", overflow, drop_cnt);
        end
        checks++;
        if (sb.size() != 2 * N_CH) begin
            errors++;
            $display("FAIL ovf_pending: got %0d queued words, required %0d", sb.size(), 2 * N_CH);
        end
        drain("ovf", 200);
    endtask

    task automatic test_overlap();
        logic [N_CH*DW-1:0] vb;
        vb = mk_vec(7'h35);
        out_ready = 1'b1;
        send(mk_vec(7'h34));
        for (int i = 0; i < N_CH - 1; i++) cycle();
        checks++;
        if (out_ch !== CW'(N_CH - 1) || out_last !== 1'b1) begin
            errors++;
            $display("FAIL overlap_pre: ch=%0d last=%b, required %0d 1", out_ch, out_last, N_CH - 1);
        end
        send(vb);
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 5'd0 || in_ready !== 1'b1 ||
            out_data !== vb[DW-1:0]) begin
            errors++;
            $display("FAIL overlap_next: vld=%b ch=%0d rdy=%b data=%h, required 1 0 1 %h",
                     out_valid, out_ch, in_ready, out_data, vb[DW-1:0]);
        end
        for (int i = 0; i < N_CH; i++) cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL overlap_count: out_valid=%b after one vector, required 0", out_valid);
        end
        drain("overlap", 10);
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        send(mk_vec(7'h41));
        for (int i = 0; i < 10; i++) cycle();
        checks++;
        if (out_ch !== 5'd10) begin
            errors++;
            $display("FAIL rst_pre: ch=%0d, required 10", out_ch);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: vld=%b ovf=%b drops=%0d rdy=%b, required 0 0 0 1",
                     out_valid, overflow, drop_cnt, in_ready);
        end
        send(mk_vec(7'h42));
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 5'd0) begin
            errors++;
            $display("FAIL rst_restart: vld=%b ch=%0d, required 1 0", out_valid, out_ch);
        end
        drain("rst", 100);
    endtask

    task automatic test_random();
        int hs0;
        hs0 = hs_cnt;
        for (int v = 0; v < 20; v++) begin
            in_valid = 1'b1;
            in_data  = rnd_vec();
            for (int t = 0; t < 40; t++) begin
                out_ready = ($urandom_range(15, 0) != 0);
                cycle();
                in_valid = 1'b0;
            end
        end
        drain("rand", 400);
        checks++;
        if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rand_drops: drop_cnt=%0d overflow=%b, required 0 0", drop_cnt, overflow);
        end
        checks++;
        if (hs_cnt - hs0 != 20 * N_CH) begin
            errors++;
            $display("FAIL rand_hs: got %0d handshakes, required %0d", hs_cnt - hs0, 20 * N_CH);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_overlap();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
